hex_display_scanner: RTL and testbench

Time-multiplexing scanner that drives the shared 4-digit 7-segment hex decoder. It latches a 16-bit display value and cycles through the four digits at a programmable refresh rate. Each cycle it presents the active digit's nibble on `bin_out` and a one-hot anode enable on `en_bus`, with a dead-time gap between digits to suppress ghosting. Value updates are deferred to frame boundaries so a frame never shows a mix of old and new digits.

---
 rtl/hex_display_pkg.sv | 21 ++
 rtl/hex_display_scanner_if.sv | 26 ++
 rtl/hex_display_scanner_prescaler.sv | 35 +++
 rtl/hex_display_scanner.sv | 116 +++++++++++
 tb/tb_hex_display_scanner.sv | 203 ++++++++++++++++++++
 5 files changed

// File: rtl/hex_display_pkg.sv
// Shared definitions for the hex display scanner.
//   NUM_DIGITS   : number of multiplexed digits
//   digit_idx_t  : digit index type
//   scan_state_t : per-slot scan phase (dead-time gap, then lit)
//   nibble_sel   : pick the 4-bit nibble for a digit out of a 16-bit value
package hex_display_pkg;

  localparam int unsigned NUM_DIGITS = 4;

  typedef logic [1:0] digit_idx_t;

  typedef enum logic [0:0] {
    StGap,
    StOn
  } scan_state_t;

  function automatic logic [3:0] nibble_sel(input logic [15:0] value, input digit_idx_t idx);
    return value[{idx, 2'b00} +: 4];
  endfunction

endpackage

// File: rtl/hex_display_scanner_if.sv
// Bus between a display-value producer and the hex display scanner.
//   value_in   : 16-bit display value (nibble k -> digit k)
//   load       : one-cycle strobe capturing value_in
//   digit_mask : per-digit enable, 1 = digit may light
//   en_bus     : one-hot digit enable to the decoder, zero during dead-time
//   bin_out    : nibble of the active digit
//   frame_tick : one-cycle pulse at the start of each frame
// master drives value/load/mask; slave (the scanner) drives the display outputs.
interface hex_display_scanner_if;
  logic [15:0] value_in;
  logic        load;
  logic [3:0]  digit_mask;
  logic [3:0]  en_bus;
  logic [3:0]  bin_out;
  logic        frame_tick;

  modport master (
    output value_in, load, digit_mask,
    input  en_bus, bin_out, frame_tick
  );

  modport slave (
    input  value_in, load, digit_mask,
    output en_bus, bin_out, frame_tick
  );
endinterface

// File: rtl/hex_display_scanner_prescaler.sv
// Slot counter for the display scanner. Counts 0..REFRESH_DIV-1 and wraps.
//   clk        : system clock
//   rst_n      : asynchronous active-low reset (count returns to 0)
//   cnt_d_o    : count value after the next clock edge
//   slot_end_o : high on the last cycle of a slot (count == REFRESH_DIV-1)
module refresh_prescaler #(
  parameter int unsigned REFRESH_DIV = 100000
) (
  input  logic                           clk,
  input  logic                           rst_n,
  output logic [$clog2(REFRESH_DIV)-1:0] cnt_d_o,
  output logic                           slot_end_o
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  // Compare against the terminal value so non-power-of-2 dividers wrap correctly.
  localparam logic [CntW-1:0] LastCnt = CntW'(REFRESH_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  always_comb begin
    slot_end_o = (cnt_q == LastCnt);
    cnt_d      = slot_end_o ? '0 : cnt_q + CntW'(1);
    cnt_d_o    = cnt_d;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/hex_display_scanner.sv
// Time-multiplexing scanner for a 4-digit 7-segment hex decoder.
// Cycles through the digits one slot (REFRESH_DIV cycles) at a time; each slot opens with
// BLANK_CYCLES of dead-time. New values are held pending and committed only at frame
// boundaries so a frame never mixes old and new digits.
//   clk   : system clock
//   rst_n : asynchronous active-low reset; outputs clear immediately
//   bus   : slave side of hex_display_scanner_if (value_in/load/digit_mask in,
//           en_bus/bin_out/frame_tick out, all outputs registered)
// Build option: define HEX_SCAN_LZB_EN to compile in leading-zero blanking.
module hex_display_scanner
  import hex_display_pkg::*;
#(
  parameter int unsigned REFRESH_DIV  = 100000,
  parameter int unsigned BLANK_CYCLES = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  hex_display_scanner_if.slave  bus
);

  localparam int unsigned CntW = $clog2(REFRESH_DIV);
  localparam logic [CntW-1:0] BlankCnt = CntW'(BLANK_CYCLES);

  logic [CntW-1:0] cnt_d;
  logic            slot_end;
  logic            frame_end;

  digit_idx_t  idx_q, idx_d;
  scan_state_t state_q, state_d;
  logic [15:0] committed_q, committed_d;
  logic [15:0] pending_q, pending_d;
  logic        pending_valid_q, pending_valid_d;
  logic [3:0]  en_bus_q, en_bus_d;
  logic [3:0]  bin_out_q, bin_out_d;
  logic        frame_tick_q, frame_tick_d;
`ifdef HEX_SCAN_LZB_EN
  logic [3:0]  lzb_mask;
`endif

  refresh_prescaler #(
    .REFRESH_DIV(REFRESH_DIV)
  ) u_prescaler (
    .clk        (clk),
    .rst_n      (rst_n),
    .cnt_d_o    (cnt_d),
    .slot_end_o (slot_end)
  );

  always_comb begin
    frame_end       = slot_end && (idx_q == digit_idx_t'(NUM_DIGITS - 1));
    idx_d           = slot_end ? idx_q + digit_idx_t'(1) : idx_q;
    state_d         = state_q;
    committed_d     = committed_q;
    pending_d       = pending_q;
    pending_valid_d = pending_valid_q;

    unique case (state_q)
      StGap:   if (cnt_d >= BlankCnt) state_d = StOn;
      StOn:    if (cnt_d < BlankCnt)  state_d = StGap;
      default: state_d = StGap;
    endcase

    if (frame_end) begin
      if (bus.load) begin
        // Load on the commit cycle bypasses straight to display; older pending is dropped.
        committed_d     = bus.value_in;
        pending_d       = bus.value_in;
        pending_valid_d = 1'b0;
      end else if (pending_valid_q) begin
        committed_d     = pending_q;
        pending_valid_d = 1'b0;
      end
    end else if (bus.load) begin
      pending_d       = bus.value_in;
      pending_valid_d = 1'b1;
    end

    // Outputs are computed from next-state so they are registered yet aligned with cnt/idx.
    en_bus_d = (state_d == StOn) ? (4'b0001 << idx_d) : 4'b0000;
    en_bus_d = en_bus_d & bus.digit_mask;
`ifdef HEX_SCAN_LZB_EN
    // Digit k lights only if some nibble at or above k is nonzero; digit 0 always lights.
    lzb_mask = {|committed_d[15:12], |committed_d[15:8], |committed_d[15:4], 1'b1};
    en_bus_d = en_bus_d & lzb_mask;
`endif
    bin_out_d    = nibble_sel(committed_d, idx_d);
    frame_tick_d = frame_end;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx_q           <= '0;
      state_q         <= StGap;
      committed_q     <= '0;
      pending_q       <= '0;
      pending_valid_q <= 1'b0;
      en_bus_q        <= '0;
      bin_out_q       <= '0;
      frame_tick_q    <= 1'b0;
    end else begin
      idx_q           <= idx_d;
      state_q         <= state_d;
      committed_q     <= committed_d;
      pending_q       <= pending_d;
      pending_valid_q <= pending_valid_d;
      en_bus_q        <= en_bus_d;
      bin_out_q       <= bin_out_d;
      frame_tick_q    <= frame_tick_d;
    end
  end

  assign bus.en_bus     = en_bus_q;
  assign bus.bin_out    = bin_out_q;
  assign bus.frame_tick = frame_tick_q;

endmodule

// File: tb/tb_hex_display_scanner.sv
// Self-checking bench for hex_display_scanner (REFRESH_DIV=8, BLANK_CYCLES=2).
module tb_hex_display_scanner;

  localparam int unsigned RD = 8;
  localparam int unsigned BC = 2;
  localparam int unsigned FRAME = 4 * RD;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  hex_display_scanner_if u_if ();

  hex_display_scanner #(
    .REFRESH_DIV  (RD),
    .BLANK_CYCLES (BC)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (u_if)
  );

  typedef struct {
    logic [3:0]  en;
    logic [3:0]  bin;
    logic        tick;
    int unsigned k;
  } exp_t;

  typedef struct {
    logic        ld;
    logic [15:0] val;
    logic [3:0]  msk;
    logic [3:0]  en;
    logic [3:0]  bin;
    logic        tick;
  } vec_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_checks = 0;
  int   n_fail   = 0;

  // Reference model: m_k counts clock edges since reset release.
  int unsigned m_k;
  logic [15:0] m_comm, m_pend;
  logic        m_pv;

  task automatic check(input string name, input int unsigned k,
                       input logic [3:0] act, input logic [3:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s at edge %0d: got %b, expected %b", name, k, act, exp);
    end
  endtask

  task automatic model_reset();
    m_k = 0; m_comm = '0; m_pend = '0; m_pv = 1'b0;
  endtask

  function automatic exp_t model_step(input logic ld, input logic [15:0] val,
                                      input logic [3:0] msk);
    exp_t        e;
    int unsigned k, c, ix;
    logic [15:0] hi;
    k  = m_k + 1;
    c  = k % RD;
    ix = (k / RD) % 4;
    if (k % FRAME == 0) begin
      if (ld) begin
        m_comm = val; m_pv = 1'b0;
      end else if (m_pv) begin
        m_comm = m_pend; m_pv = 1'b0;
      end
    end else if (ld) begin
      m_pend = val; m_pv = 1'b1;
    end
    e.en = (c >= BC) ? 4'(1 << ix) : 4'b0000;
    e.en = e.en & msk;
    hi   = m_comm >> (4 * ix);
`ifdef HEX_SCAN_LZB_EN
    if (ix != 0 && hi == 16'h0) e.en = 4'b0000;
`endif
    e.bin  = m_comm[4*ix +: 4];
    e.tick = (k % FRAME == 0);
    e.k    = k;
    m_k    = k;
    return e;
  endfunction

  task automatic drive(input logic ld, input logic [15:0] val, input logic [3:0] msk);
    @(negedge clk);
    u_if.load       = ld;
    u_if.value_in   = val;
    u_if.digit_mask = msk;
  endtask

  task automatic cyc(input logic ld, input logic [15:0] val, input logic [3:0] msk);
    drive(ld, val, msk);
    sb_q.push_back(model_step(ld, val, msk));
  endtask

  // Idle cycles (random value_in, no load) until the model reaches edge kk.
  task automatic run_until(input int unsigned kk, input logic [3:0] msk);
    while (m_k < kk) cyc(1'b0, 16'($urandom), msk);
  endtask

  // Scoreboard consumer: compare each edge's outputs against the queued expectation.
  always @(posedge clk) begin
    #2;
    if (sb_q.size() != 0) begin
      mon_e = sb_q.pop_front();
      check("en_bus", mon_e.k, u_if.en_bus, mon_e.en);
      check("bin_out", mon_e.k, u_if.bin_out, mon_e.bin);
      check("frame_tick", mon_e.k, {3'b000, u_if.frame_tick}, {3'b000, mon_e.tick});
    end
  end

  vec_t tbl[12];

  initial begin
    exp_t dummy;
    // First 12 edges after reset: dead-time, digit 0 lit with value 0, then digit 1;
    // A5C3 loaded mid-frame must not disturb the current frame.
    tbl[0]  = '{1'b0, 16'h0000, 4'hF, 4'b0000, 4'h0, 1'b0};
    tbl[1]  = '{1'b0, 16'h0000, 4'hF, 4'b0001, 4'h0, 1'b0};
    tbl[2]  = '{1'b0, 16'h0000, 4'hF, 4'b0001, 4'h0, 1'b0};
    tbl[3]  = '{1'b0, 16'h0000, 4'hF, 4'b0001, 4'h0, 1'b0};
    tbl[4]  = '{1'b0, 16'h0000, 4'hF, 4'b0001, 4'h0, 1'b0};
    tbl[5]  = '{1'b0, 16'h0000, 4'hF, 4'b0001, 4'h0, 1'b0};
    tbl[6]  = '{1'b0, 16'h0000, 4'hF, 4'b0001, 4'h0, 1'b0};
    tbl[7]  = '{1'b0, 16'h0000, 4'hF, 4'b0000, 4'h0, 1'b0};
    tbl[8]  = '{1'b0, 16'h0000, 4'hF, 4'b0000, 4'h0, 1'b0};
    tbl[9]  = '{1'b1, 16'hA5C3, 4'hF, 4'b0010, 4'h0, 1'b0};
    tbl[10] = '{1'b0, 16'h0000, 4'hF, 4'b0010, 4'h0, 1'b0};
    tbl[11] = '{1'b0, 16'h0000, 4'hF, 4'b0010, 4'h0, 1'b0};

    rst_n           = 1'b0;
    u_if.load       = 1'b0;
    u_if.value_in   = '0;
    u_if.digit_mask = 4'hF;
    model_reset();
    #12;
    check("reset en_bus", 0, u_if.en_bus, 4'b0000);
    check("reset bin_out", 0, u_if.bin_out, 4'h0);
    check("reset frame_tick", 0, {3'b000, u_if.frame_tick}, 4'b0000);

    @(posedge clk);
    #2 rst_n = 1'b1;

    for (int i = 0; i < 12; i++) begin
      drive(tbl[i].ld, tbl[i].val, tbl[i].msk);
      dummy = model_step(tbl[i].ld, tbl[i].val, tbl[i].msk);
      sb_q.push_back('{tbl[i].en, tbl[i].bin, tbl[i].tick, dummy.k});
    end

    // A5C3 commits at edge 32; frame 32..63 shows 3,C,5,A.
    run_until(71, 4'hF);
    // Overwrite: only 5678 may reach the display.
    cyc(1'b1, 16'h1234, 4'hF);
    run_until(75, 4'hF);
    cyc(1'b1, 16'h5678, 4'hF);
    run_until(109, 4'hF);
    // Load on the commit edge (128) while 1111 is pending.
    cyc(1'b1, 16'h1111, 4'hF);
    run_until(127, 4'hF);
    cyc(1'b1, 16'hBEEF, 4'hF);
    // Frame at 160 must still show BEEF (pending cleared).
    run_until(170, 4'hF);
    // Mask 0101: digits 1 and 3 stay dark.
    run_until(210, 4'b0101);

    // Edge 210: digit 2 lit, nibble E. Assert reset between edges.
    @(negedge clk);
    #2;
    check("pre-reset en_bus", 210, u_if.en_bus, 4'b0100);
    check("pre-reset bin_out", 210, u_if.bin_out, 4'hE);
    rst_n = 1'b0;
    #1;
    check("async reset en_bus", 210, u_if.en_bus, 4'b0000);
    check("async reset bin_out", 210, u_if.bin_out, 4'h0);
    check("async reset frame_tick", 210, {3'b000, u_if.frame_tick}, 4'b0000);
    repeat (3) @(posedge clk);
    #2;
    rst_n = 1'b1;
    model_reset();

    // Restart from digit 0; then leading-zero cases.
    run_until(20, 4'hF);
    cyc(1'b1, 16'h0042, 4'hF);
    run_until(70, 4'hF);
    cyc(1'b1, 16'h0000, 4'hF);
    run_until(100, 4'hF);

    @(posedge clk);
    #4;
    check("scoreboard drained", m_k, 4'(sb_q.size()), 4'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
